bp_fe_bp_update_queue: RTL and testbench

//  Buffers branch-resolution updates from the backend and drains them into the

---
 rtl/bp_fe_pkg.sv | 17 +
 rtl/bp_fe_bp_update_fifo.sv | 50 +++++
 rtl/bp_fe_bp_update_queue.sv | 72 +++++++
 tb/tb_bp_fe_bp_update_queue.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared front-end branch-predictor types and default sizing.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_DECLARE_BHT_UPDATE_S(idx_width_mp) \
   typedef struct packed { \
      logic [idx_width_mp-1:0] idx; \
      logic                    correct; \
   } bp_fe_bht_update_s

package bp_fe_pkg;
   localparam int bp_fe_bht_idx_width_dflt = 8;
   localparam int bp_fe_upd_els_dflt       = 4;
   localparam int bp_fe_starve_cycles_dflt = 8;
endpackage

`endif

// File: rtl/bp_fe_bp_update_fifo.sv
// Circular buffer of BHT updates with register storage and async head read.
// Latency: enqueued entry visible at the head one cycle later, never bypassed.
// Backpressure: caller must gate enq_i with ~full_o and deq_i with ~empty_o.
module bp_fe_bp_update_fifo
   import bp_fe_pkg::*;
#(
   parameter int width_p = bp_fe_bht_idx_width_dflt + 1,
   parameter int els_p   = bp_fe_upd_els_dflt,
   localparam int ptr_width_lp = $clog2(els_p),
   localparam int cnt_width_lp = $clog2(els_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    enq_i,
   input  logic [width_p-1:0]      data_i,
   input  logic                    deq_i,
   output logic [width_p-1:0]      data_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [cnt_width_lp-1:0] count_o
);

   logic [width_p-1:0]      mem [els_p];
   logic [ptr_width_lp-1:0] wr_ptr;
   logic [ptr_width_lp-1:0] rd_ptr;
   logic [cnt_width_lp-1:0] count;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by natural overflow.
         if (enq_i) wr_ptr <= wr_ptr + 1'b1;
         if (deq_i) rd_ptr <= rd_ptr + 1'b1;
         count <= count + cnt_width_lp'(enq_i) - cnt_width_lp'(deq_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq_i) mem[wr_ptr] <= data_i;
   end

   assign data_o  = mem[rd_ptr];
   assign full_o  = (count == cnt_width_lp'(els_p));
   assign empty_o = (count == '0);
   assign count_o = count;

endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// Queues backend branch resolutions and drains them into the BHT write port.
// Latency: >= 1 cycle enqueue to w_v_o; writes wait while the BHT is being read.
// Backpressure: upd_ready_o low when full; starvation guard stalls the reader.
module bp_fe_bp_update_queue
   import bp_fe_pkg::*;
#(
   parameter int bht_idx_width_p = bp_fe_bht_idx_width_dflt,
   parameter int els_p           = bp_fe_upd_els_dflt,
   parameter int starve_cycles_p = bp_fe_starve_cycles_dflt,
   localparam int cnt_width_lp    = $clog2(els_p + 1),
   localparam int starve_width_lp = $clog2(starve_cycles_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       upd_v_i,
   output logic                       upd_ready_o,
   input  logic [bht_idx_width_p-1:0] upd_idx_i,
   input  logic                       upd_correct_i,
   input  logic                       rd_busy_i,
   output logic                       rd_stall_o,
   output logic                       w_v_o,
   output logic [bht_idx_width_p-1:0] idx_w_o,
   output logic                       correct_o,
   output logic [cnt_width_lp-1:0]    count_o
);

   `BP_FE_DECLARE_BHT_UPDATE_S(bht_idx_width_p);

   bp_fe_bht_update_s          upd_entry, head_entry;
   logic                       enq, deq, full, empty, force_w;
   logic [starve_width_lp-1:0] starve_cnt;

   assign upd_entry = '{idx: upd_idx_i, correct: upd_correct_i};
   assign enq       = upd_v_i & ~full;

   bp_fe_bp_update_fifo #(
      .width_p (bht_idx_width_p + 1),
      .els_p   (els_p)
   ) fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .enq_i   (enq),
      .data_i  (upd_entry),
      .deq_i   (deq),
      .data_o  (head_entry),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count_o)
   );

   assign force_w     = (starve_cnt == starve_width_lp'(starve_cycles_p));
   assign deq         = ~empty & (~rd_busy_i | force_w);
   assign w_v_o       = deq;
   assign rd_stall_o  = deq & rd_busy_i;
   assign upd_ready_o = ~full;
   assign idx_w_o     = empty ? '0 : head_entry.idx;
   assign correct_o   = empty ? 1'b0 : head_entry.correct;

   // A head that is not dequeued implies a busy, unforced cycle, so count up.
   always_ff @(posedge clk_i) begin
      if (reset_i || deq || empty) starve_cnt <= '0;
      else if (!force_w)           starve_cnt <= starve_cnt + 1'b1;
   end

`ifndef SYNTHESIS
   a_hold_idx: assert property (@(posedge clk_i) disable iff (reset_i)
      (upd_v_i & ~upd_ready_o) |=> $stable(upd_idx_i));
   a_count_max: assert property (@(posedge clk_i) disable iff (reset_i)
      count_o <= cnt_width_lp'(els_p));
`endif

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed table-driven bench for bp_fe_bp_update_queue (idx width 4, depth 4, starve 8).
module tb_bp_fe_bp_update_queue;
   import bp_fe_pkg::*;

   localparam int IW = 4;
   localparam int CW = 3;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          upd_v_i = 1'b0;
   logic          upd_ready_o;
   logic [IW-1:0] upd_idx_i = '0;
   logic          upd_correct_i = 1'b0;
   logic          rd_busy_i = 1'b0;
   logic          rd_stall_o;
   logic          w_v_o;
   logic [IW-1:0] idx_w_o;
   logic          correct_o;
   logic [CW-1:0] count_o;

   int checks = 0;
   int errors = 0;

   bp_fe_bp_update_queue #(
      .bht_idx_width_p (IW),
      .els_p           (4),
      .starve_cycles_p (8)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .upd_v_i       (upd_v_i),
      .upd_ready_o   (upd_ready_o),
      .upd_idx_i     (upd_idx_i),
      .upd_correct_i (upd_correct_i),
      .rd_busy_i     (rd_busy_i),
      .rd_stall_o    (rd_stall_o),
      .w_v_o         (w_v_o),
      .idx_w_o       (idx_w_o),
      .correct_o     (correct_o),
      .count_o       (count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          rst;
      logic          v;
      logic [IW-1:0] idx;
      logic          c;
      logic          busy;
      logic          e_ready;
      logic          e_wv;
      logic          e_stall;
      logic [IW-1:0] e_idx;
      logic          e_c;
      logic [CW-1:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, v, input logic [IW-1:0] idx, input logic c,
                               input logic busy, e_ready, e_wv, e_stall,
                               input logic [IW-1:0] e_idx, input logic e_c,
                               input logic [CW-1:0] e_cnt);
      vec_t t;
      t = '{rst, v, idx, c, busy, e_ready, e_wv, e_stall, e_idx, e_c, e_cnt};
      vecs.push_back(t);
   endfunction

   // Drive one cycle's inputs after the edge, then check the combinational view.
   task automatic drive(input logic rst, v, input logic [IW-1:0] idx, input logic c,
                        input logic busy);
      @(posedge clk_i);
      #1;
      reset_i = rst; upd_v_i = v; upd_idx_i = idx; upd_correct_i = c; rd_busy_i = busy;
      #1;
   endtask

   task automatic check(input string name, input logic e_ready, e_wv, e_stall,
                        input logic [IW-1:0] e_idx, input logic e_c,
                        input logic [CW-1:0] e_cnt);
      logic [IW+CW+3:0] act, exp;
      act = {upd_ready_o, w_v_o, rd_stall_o, idx_w_o, correct_o, count_o};
      exp = {e_ready, e_wv, e_stall, e_idx, e_c, e_cnt};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got rdy=%b wv=%b stall=%b idx=%h c=%b cnt=%0d, want rdy=%b wv=%b stall=%b idx=%h c=%b cnt=%0d",
                  name, upd_ready_o, w_v_o, rd_stall_o, idx_w_o, correct_o, count_o,
                  e_ready, e_wv, e_stall, e_idx, e_c, e_cnt);
      end
   endtask

   initial begin
      // Idle after reset
      for (int i = 0; i < 10; i++) add(0,0,0,0,0, 1,0,0,0,0,0);
      // Back-to-back drain with reader idle
      add(0,1,3,1,0, 1,0,0,0,0,0);
      add(0,1,5,0,0, 1,1,0,3,1,1);
      add(0,1,7,1,0, 1,1,0,5,0,1);
      add(0,0,0,0,0, 1,1,0,7,1,1);
      add(0,0,0,0,0, 1,0,0,0,0,0);
      // Fill while reader busy, fifth held
      add(0,1,1,0,1, 1,0,0,0,0,0);
      add(0,1,2,1,1, 1,0,0,1,0,1);
      add(0,1,3,0,1, 1,0,0,1,0,2);
      add(0,1,4,1,1, 1,0,0,1,0,3);
      add(0,1,5,0,1, 0,0,0,1,0,4);
      add(0,1,5,0,1, 0,0,0,1,0,4);
      // Full with reader free: dequeue only, then enqueue into wrapped slot 0
      add(0,1,5,0,0, 0,1,0,1,0,4);
      add(0,1,5,0,0, 1,1,0,2,1,3);
      add(0,0,0,0,0, 1,1,0,3,0,3);
      add(0,0,0,0,0, 1,1,0,4,1,2);
      add(0,0,0,0,0, 1,1,0,5,0,1);
      add(0,0,0,0,0, 1,0,0,0,0,0);
      // Reset with three entries pending
      add(0,1,9,1,1,  1,0,0,0,0,0);
      add(0,1,10,0,1, 1,0,0,9,1,1);
      add(0,1,11,1,1, 1,0,0,9,1,2);
      add(1,0,0,0,1,  1,0,0,9,1,3);
      add(0,0,0,0,0,  1,0,0,0,0,0);
      add(0,0,0,0,1,  1,0,0,0,0,0);
      add(0,0,0,0,0,  1,0,0,0,0,0);

      reset_i = 1'b1;
      repeat (3) @(posedge clk_i);
      drive(1,0,0,0,0);
      check("reset", 1,0,0,0,0,0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].idx, vecs[i].c, vecs[i].busy);
         check($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wv, vecs[i].e_stall,
               vecs[i].e_idx, vecs[i].e_c, vecs[i].e_cnt);
      end

      // Starvation: two entries under a permanently busy reader
      drive(0,1,6,1,1);
      check("starve_enq", 1,0,0,0,0,0);
      for (int k = 0; k <= 8; k++) begin
         if (k == 0) drive(0,1,12,0,1);
         else        drive(0,0,0,0,1);
         check($sformatf("starve_a%0d", k), 1, k == 8, k == 8, 6, 1, (k == 0) ? 3'd1 : 3'd2);
      end
      for (int k = 0; k <= 8; k++) begin
         drive(0,0,0,0,1);
         check($sformatf("starve_b%0d", k), 1, k == 8, k == 8, 12, 0, 1);
      end
      drive(0,0,0,0,1);
      check("starve_done", 1,0,0,0,0,0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
